// File: rtl/fetch_ctrl_pkg.sv
// Shared types and widths for the instruction-fetch sequencing controller.
package fetch_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } fc_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of IF/ID.
module load_use_detect
    import fetch_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    output logic                  hazard
);

    logic rd_nonzero;
    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign rd_nonzero = (ex_rd != '0);
    assign rs1_match  = (ex_rd == id_rs1);
    assign rs2_match  = id_uses_rs2 && (ex_rd == id_rs2);
    assign hazard     = ex_mem_read && rd_nonzero && (rs1_match || rs2_match);

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage and IF/ID sequencing: boot hold, load-use stall, branch redirect,
// halt/resume, plus saturating stall/flush performance counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// BOOT     | front end held after reset for BOOT_CYCLES edges
// RUN      | normal fetch; stalls, redirects and halts resolved here
// REDIRECT | one cycle flushing the stale word from the sync instr memory
// HALT     | ECALL/EBREAK parked; waits for a resume pulse
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int PERF_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic                  ex_branch_taken,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pcWrite,
    output logic                  pcSrc,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  halted,
    output logic [PERF_W-1:0]     stall_count,
    output logic [PERF_W-1:0]     flush_count
);

    localparam logic [7:0] BOOT_LOAD = 8'(BOOT_CYCLES);

    fc_state_t   state;
    logic [7:0]  boot_cnt;
    logic        load_use;
    logic        stall_sat;
    logic        flush_sat;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .hazard      (load_use)
    );

    assign stall_sat = (stall_count == '1);
    assign flush_sat = (flush_count == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            boot_cnt    <= BOOT_LOAD;
            stall_count <= '0;
            flush_count <= '0;
            halted      <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    // <= 1 also guards against an out-of-range zero load
                    if (boot_cnt <= 8'd1) begin
                        state <= RUN;
                    end else begin
                        boot_cnt <= boot_cnt - 8'd1;
                    end
                end
                RUN: begin
                    if (ex_branch_taken) begin
                        state <= REDIRECT;
                        if (!flush_sat) begin
                            flush_count <= flush_count + PERF_W'(1);
                        end
                    end else if (load_use) begin
                        if (!stall_sat) begin
                            stall_count <= stall_count + PERF_W'(1);
                        end
                    end else if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (ex_branch_taken) begin
                        if (!flush_sat) begin
                            flush_count <= flush_count + PERF_W'(1);
                        end
                    end else begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Mealy control outputs; a taken branch outranks the stall and halt because
    // both younger instructions are being thrown away anyway.
    always_comb begin
        pcWrite     = 1'b0;
        pcSrc       = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b1;
        case (state)
            BOOT: begin
                if_id_flush = 1'b1;
            end
            RUN: begin
                if (ex_branch_taken) begin
                    pcWrite     = 1'b1;
                    pcSrc       = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                end else if (load_use || halt_req) begin
                    id_ex_flush = 1'b1;
                end else begin
                    pcWrite     = 1'b1;
                    if_id_write = 1'b1;
                    id_ex_flush = 1'b0;
                end
            end
            REDIRECT: begin
                pcWrite     = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                if (ex_branch_taken) begin
                    pcSrc = 1'b1;
                end else begin
                    id_ex_flush = 1'b0;
                end
            end
            HALT: begin
                id_ex_flush = 1'b1;
            end
            default: begin
                if_id_flush = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a cycle-level reference model.
module tb_fetch_controller;

    localparam int BOOT = 4;
    localparam int PW   = 4;
    localparam int SAT  = (1 << PW) - 1;

    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_REDIR = 2;
    localparam int M_HALT  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ex_mem_read;
    logic [4:0]    ex_rd;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_uses_rs2;
    logic          ex_branch_taken;
    logic          halt_req;
    logic          resume;
    logic          pcWrite;
    logic          pcSrc;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          halted;
    logic [PW-1:0] stall_count;
    logic [PW-1:0] flush_count;

    int errors = 0;
    int checks = 0;

    int m_mode;
    int m_left;
    int m_stall;
    int m_flush;
    bit m_halted;

    always #5 clk = ~clk;

    fetch_controller #(.BOOT_CYCLES(BOOT), .PERF_W(PW)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_branch_taken (ex_branch_taken),
        .halt_req        (halt_req),
        .resume          (resume),
        .pcWrite         (pcWrite),
        .pcSrc           (pcSrc),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .halted          (halted),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_hazard();
        int rd = int'(ex_rd);
        if (!ex_mem_read || rd == 0) return 1'b0;
        if (rd == int'(id_rs1)) return 1'b1;
        return id_uses_rs2 && (rd == int'(id_rs2));
    endfunction

    // {pcWrite, pcSrc, if_id_write, if_id_flush, id_ex_flush}
    function automatic logic [4:0] exp_ctrl();
        case (m_mode)
            M_BOOT:  return 5'b00011;
            M_RUN: begin
                if (ex_branch_taken) return 5'b11111;
                if (ref_hazard() || halt_req) return 5'b00001;
                return 5'b10100;
            end
            M_REDIR: return ex_branch_taken ? 5'b11111 : 5'b10110;
            default: return 5'b00001;
        endcase
    endfunction

    task automatic model_edge();
        case (m_mode)
            M_BOOT: begin
                if (m_left <= 1) m_mode = M_RUN;
                else m_left--;
            end
            M_RUN: begin
                if (ex_branch_taken) begin
                    if (m_flush < SAT) m_flush++;
                    m_mode = M_REDIR;
                end else if (ref_hazard()) begin
                    if (m_stall < SAT) m_stall++;
                end else if (halt_req) begin
                    m_mode = M_HALT;
                end
            end
            M_REDIR: begin
                if (ex_branch_taken) begin
                    if (m_flush < SAT) m_flush++;
                end else begin
                    m_mode = M_RUN;
                end
            end
            default: if (resume) m_mode = M_RUN;
        endcase
        m_halted = (m_mode == M_HALT);
    endtask

    task automatic drive(input bit mr, input int rd, input int r1, input int r2,
                         input bit u2, input bit br, input bit hr, input bit rs);
        ex_mem_read     = mr;
        ex_rd           = 5'(rd);
        id_rs1          = 5'(r1);
        id_rs2          = 5'(r2);
        id_uses_rs2     = u2;
        ex_branch_taken = br;
        halt_req        = hr;
        resume          = rs;
    endtask

    // Entered at posedge+1; checks the combinational outputs, crosses one edge,
    // then checks the registered outputs.
    task automatic step(output bit pw_obs);
        #3;
        check("ctrl", {pcWrite, pcSrc, if_id_write, if_id_flush, id_ex_flush}, exp_ctrl());
        pw_obs = pcWrite;
        @(posedge clk);
        #1;
        model_edge();
        check("halted", halted, m_halted);
        check("stall_count", stall_count, m_stall);
        check("flush_count", flush_count, m_flush);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_ctrl", {pcWrite, pcSrc, if_id_write, if_id_flush, id_ex_flush}, 5'b00011);
        check("rst_halted", halted, 0);
        check("rst_stall", stall_count, 0);
        check("rst_flush", flush_count, 0);
        m_mode   = M_BOOT;
        m_left   = BOOT;
        m_stall  = 0;
        m_flush  = 0;
        m_halted = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit pw;
        int first;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        first = -1;
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            step(pw);
            if (pw) begin
                first = k;
                break;
            end
        end
        check("boot_len", first, BOOT);

        drive(1, 5, 0, 5, 1, 0, 0, 0);
        step(pw);
        check("stall_first", stall_count, 1);
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        step(pw);
        check("stall_x0", stall_count, 1);
        drive(1, 7, 7, 3, 0, 0, 0, 0);
        step(pw);
        drive(1, 7, 3, 7, 0, 0, 0, 0);
        step(pw);
        check("stall_rs2_gated", stall_count, 2);

        drive(1, 5, 5, 5, 1, 1, 1, 0);
        step(pw);
        check("br_flush", flush_count, 1);
        check("br_stall_kept", stall_count, 2);
        check("br_not_halted", halted, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(pw);
        step(pw);

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step(pw);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step(pw);
        check("halt_enter", halted, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(pw);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step(pw);
        check("halt_leave", halted, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(pw);
        check("resume_pcwrite", pw, 1);

        for (int k = 0; k < 20; k++) begin
            drive(1, 9, 9, 0, 0, 0, 0, 0);
            step(pw);
        end
        check("stall_sat", stall_count, SAT);
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            step(pw);
        end
        check("flush_sat", flush_count, SAT);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(pw);

        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step(pw);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(pw);
        check("pre_reset_halted", halted, 1);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
                step(pw);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
